// File: rtl/count_stream_checker_pkg.sv
// Shared definitions for the count stream checker and its counter source.
// Holds FSM state encoding, LFSR seed and taps, and default bus widths.
// No logic; compile first.
package count_stream_checker_pkg;

   // Default widths, shared with the counter source so both ends agree.
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_CNT_WIDTH  = 32;

   // Checker FSM: SEEK waits for a start-of-frame beat, TRACK compares.
   typedef enum logic {
      ST_SEEK  = 1'b0,
      ST_TRACK = 1'b1
   } state_t;

   // 16-bit maximal-length Fibonacci LFSR, x^16+x^14+x^13+x^11+1.
   // The register shifts right, so the taps land on bits 0,2,3,5.
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/count_stream_checker_lfsr16.sv
// 16-bit Fibonacci LFSR, free running, loads seed_i while in reset.
// Latency: state_o is the registered state, advancing once per clk_i edge.
// Backpressure: none; it never stalls.
// Ports: clk_i, rst_ni (async active-low), seed_i (reset value), state_o.
module lfsr16
   import count_stream_checker_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [15:0] seed_i,
   output logic [15:0] state_o
);

   logic [15:0] state_q;
   logic        fb;

   assign fb = ^(state_q & LFSR_TAPS);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= seed_i;
      end else begin
         state_q <= {fb, state_q[15:1]};
      end
   end

   assign state_o = state_q;

endmodule

// File: rtl/count_stream_checker.sv
// AXI4-Stream sink checking an incrementing count for continuity; locks on tuser.
// Latency: all status outputs are registered, updating 1 cycle after an accepted beat.
// Backpressure: tready is 1 from the first cycle after reset; with
// COUNT_CHECK_STALL_EN defined it follows bit 0 of a free-running LFSR instead.
// Ports: clk_i, rst_ni, clear_i, s_axis_{tdata,tvalid,tready,tuser,tlast},
//        locked_o, error_o, err/beat/frame/line counts, first_exp_o, first_got_o.
module count_stream_checker
   import count_stream_checker_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clear_i,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tuser,
   input  logic                  s_axis_tlast,
   output logic                  locked_o,
   output logic                  error_o,
   output logic [CNT_WIDTH-1:0]  err_count_o,
   output logic [CNT_WIDTH-1:0]  beat_count_o,
   output logic [CNT_WIDTH-1:0]  frame_count_o,
   output logic [CNT_WIDTH-1:0]  line_count_o,
   output logic [DATA_WIDTH-1:0] first_exp_o,
   output logic [DATA_WIDTH-1:0] first_got_o
);

   localparam logic [DATA_WIDTH-1:0] DATA_ONE = 1;
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = 1;
   localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;

   state_t                state_q, state_d;
   logic                  rdy_q;
   logic                  accept;
   logic                  mismatch;
   logic [DATA_WIDTH-1:0] exp_q;
   logic [DATA_WIDTH-1:0] next_exp;
   logic                  err_q;
   logic [CNT_WIDTH-1:0]  err_cnt_q, beat_cnt_q, frame_cnt_q, line_cnt_q;
   logic [DATA_WIDTH-1:0] first_exp_q, first_got_q;

   assign accept   = s_axis_tvalid & rdy_q;
   // Wraps naturally modulo 2^DATA_WIDTH, so all-ones followed by 0 matches.
   assign next_exp = s_axis_tdata + DATA_ONE;
   assign mismatch = accept && (state_q == ST_TRACK) && !s_axis_tuser
                     && (s_axis_tdata != exp_q);

   // Ready generation: registered so it never depends on tvalid.
`ifdef COUNT_CHECK_STALL_EN
   logic [15:0] lfsr_state;

   lfsr16 u_lfsr (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .seed_i  (LFSR_SEED),
      .state_o (lfsr_state)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rdy_q <= 1'b0;
      else         rdy_q <= lfsr_state[0];
   end
`else
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rdy_q <= 1'b0;
      else         rdy_q <= 1'b1;
   end
`endif

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= ST_SEEK;
      else         state_q <= state_d;
   end

   // FSM next state: clear wins over any handshake; tuser always (re)locks.
   always_comb begin
      state_d = state_q;
      if (clear_i) begin
         state_d = ST_SEEK;
      end else if (accept && s_axis_tuser) begin
         state_d = ST_TRACK;
      end
   end

   // Expected count, statistics and first-mismatch capture.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         exp_q       <= '0;
         err_q       <= 1'b0;
         err_cnt_q   <= '0;
         beat_cnt_q  <= '0;
         frame_cnt_q <= '0;
         line_cnt_q  <= '0;
         first_exp_q <= '0;
         first_got_q <= '0;
      end else if (clear_i) begin
         exp_q       <= '0;
         err_q       <= 1'b0;
         err_cnt_q   <= '0;
         beat_cnt_q  <= '0;
         frame_cnt_q <= '0;
         line_cnt_q  <= '0;
         first_exp_q <= '0;
         first_got_q <= '0;
      end else if (accept) begin
         if (beat_cnt_q != CNT_MAX) beat_cnt_q <= beat_cnt_q + CNT_ONE;
         if (s_axis_tuser && frame_cnt_q != CNT_MAX) frame_cnt_q <= frame_cnt_q + CNT_ONE;
         if (s_axis_tlast && line_cnt_q != CNT_MAX)  line_cnt_q  <= line_cnt_q + CNT_ONE;
         // Resync on every tracked or start-of-frame beat, so a single
         // glitch costs exactly one error rather than a cascade.
         if (s_axis_tuser || state_q == ST_TRACK) exp_q <= next_exp;
         if (mismatch) begin
            if (err_cnt_q != CNT_MAX) err_cnt_q <= err_cnt_q + CNT_ONE;
            err_q <= 1'b1;
            if (!err_q) begin
               first_exp_q <= exp_q;
               first_got_q <= s_axis_tdata;
            end
         end
      end
   end

   assign s_axis_tready = rdy_q;
   assign locked_o      = (state_q == ST_TRACK);
   assign error_o       = err_q;
   assign err_count_o   = err_cnt_q;
   assign beat_count_o  = beat_cnt_q;
   assign frame_count_o = frame_cnt_q;
   assign line_count_o  = line_cnt_q;
   assign first_exp_o   = first_exp_q;
   assign first_got_o   = first_got_q;

endmodule

// File: tb/tb_count_stream_checker.sv
// Self-checking bench for count_stream_checker (DATA_WIDTH=8, CNT_WIDTH=8).
// Directed scenarios with literal expectations, then randomized traffic against
// an arithmetic reference model compared on every falling clock edge.
module tb_count_stream_checker;

   localparam int DW      = 8;
   localparam int CW      = 8;
   localparam int CNT_MAX = 255;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          clear_i = 1'b0;
   logic [DW-1:0] s_axis_tdata = '0;
   logic          s_axis_tvalid = 1'b0;
   logic          s_axis_tready;
   logic          s_axis_tuser = 1'b0;
   logic          s_axis_tlast = 1'b0;
   logic          locked_o, error_o;
   logic [CW-1:0] err_count_o, beat_count_o, frame_count_o, line_count_o;
   logic [DW-1:0] first_exp_o, first_got_o;

   int checks = 0;
   int errors = 0;

   count_stream_checker #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .clear_i       (clear_i),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tuser  (s_axis_tuser),
      .s_axis_tlast  (s_axis_tlast),
      .locked_o      (locked_o),
      .error_o       (error_o),
      .err_count_o   (err_count_o),
      .beat_count_o  (beat_count_o),
      .frame_count_o (frame_count_o),
      .line_count_o  (line_count_o),
      .first_exp_o   (first_exp_o),
      .first_got_o   (first_got_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0d (0x%0h) want %0d (0x%0h) at %0t", name, got, got, want, want, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int m_locked, m_err, m_errs, m_beats, m_frames, m_lines, m_fe, m_fg, m_exp, m_rdy;

   function automatic int sat(input int v);
      return (v < CNT_MAX) ? v + 1 : v;
   endfunction

   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         m_locked = 0; m_err = 0; m_errs = 0; m_beats = 0; m_frames = 0;
         m_lines = 0; m_fe = 0; m_fg = 0; m_exp = 0; m_rdy = 0;
      end else begin
         if (clear_i) begin
            m_locked = 0; m_err = 0; m_errs = 0; m_beats = 0; m_frames = 0;
            m_lines = 0; m_fe = 0; m_fg = 0; m_exp = 0;
         end else if (s_axis_tvalid && s_axis_tready) begin
            m_beats = sat(m_beats);
            if (s_axis_tuser) m_frames = sat(m_frames);
            if (s_axis_tlast) m_lines = sat(m_lines);
            if (m_locked != 0 && !s_axis_tuser && int'(s_axis_tdata) != m_exp) begin
               m_errs = sat(m_errs);
               if (m_err == 0) begin
                  m_fe = m_exp;
                  m_fg = int'(s_axis_tdata);
               end
               m_err = 1;
            end
            if (s_axis_tuser) m_locked = 1;
            if (m_locked != 0) m_exp = (int'(s_axis_tdata) + 1) % 256;
         end
         m_rdy = 1;
      end
   end

   // ---------------- per-cycle compare ----------------
   int rdy_hi = 0;
   int rdy_lo = 0;

   always @(negedge clk_i) begin
      if (rst_ni) begin
`ifdef COUNT_CHECK_STALL_EN
         if (s_axis_tready) rdy_hi++; else rdy_lo++;
`else
         chk("tready", int'(s_axis_tready), m_rdy);
`endif
         chk("locked", int'(locked_o), m_locked);
         chk("error", int'(error_o), m_err);
         chk("err_count", int'(err_count_o), m_errs);
         chk("beat_count", int'(beat_count_o), m_beats);
         chk("frame_count", int'(frame_count_o), m_frames);
         chk("line_count", int'(line_count_o), m_lines);
         chk("first_exp", int'(first_exp_o), m_fe);
         chk("first_got", int'(first_got_o), m_fg);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic beat(input logic [DW-1:0] d, input logic u, input logic l);
      int   n;
      logic got;
      n = 0;
      s_axis_tdata = d; s_axis_tuser = u; s_axis_tlast = l; s_axis_tvalid = 1'b1;
      forever begin
         got = s_axis_tready;
         @(negedge clk_i);
         if (got) break;
         n++;
         if (n > 64) begin
            checks++; errors++;
            $display("FAIL beat_timeout got no tready want tready within 64 cycles");
            break;
         end
      end
      s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
   endtask

   task automatic do_clear();
      clear_i = 1'b1;
      @(negedge clk_i);
      clear_i = 1'b0;
   endtask

   task automatic all_zero(input string tag);
      chk({tag, "_tready"}, int'(s_axis_tready), 0);
      chk({tag, "_locked"}, int'(locked_o), 0);
      chk({tag, "_error"}, int'(error_o), 0);
      chk({tag, "_errs"}, int'(err_count_o), 0);
      chk({tag, "_beats"}, int'(beat_count_o), 0);
      chk({tag, "_frames"}, int'(frame_count_o), 0);
      chk({tag, "_lines"}, int'(line_count_o), 0);
      chk({tag, "_fe"}, int'(first_exp_o), 0);
      chk({tag, "_fg"}, int'(first_got_o), 0);
   endtask

   initial begin
      int cnt;
      logic [DW-1:0] d;
      repeat (2) @(negedge clk_i);
      all_zero("reset");
      rst_ni = 1'b1;
      chk("tready_before_edge", int'(s_axis_tready), 0);
      @(negedge clk_i);

      // Clean stream: 0x10 with tuser, then 0x11..0x1F, tlast on the last.
      beat(8'h10, 1'b1, 1'b0);
      for (int i = 1; i < 16; i++) beat(8'(8'h10 + i), 1'b0, i == 15);
      chk("clean_locked", int'(locked_o), 1);
      chk("clean_errs", int'(err_count_o), 0);
      chk("clean_beats", int'(beat_count_o), 16);
      chk("clean_frames", int'(frame_count_o), 1);
      chk("clean_lines", int'(line_count_o), 1);

      // Single glitch: 4(tuser),5,6,9,10,11.
      do_clear();
      beat(8'd4, 1'b1, 1'b0);
      beat(8'd5, 1'b0, 1'b0);
      beat(8'd6, 1'b0, 1'b0);
      beat(8'd9, 1'b0, 1'b0);
      beat(8'd10, 1'b0, 1'b0);
      beat(8'd11, 1'b0, 1'b0);
      chk("glitch_errs", int'(err_count_o), 1);
      chk("glitch_error", int'(error_o), 1);
      chk("glitch_fe", int'(first_exp_o), 7);
      chk("glitch_fg", int'(first_got_o), 9);
      chk("glitch_beats", int'(beat_count_o), 6);

      // Clear in the same cycle as an accepted mismatching beat.
      clear_i = 1'b1;
      beat(8'h55, 1'b0, 1'b1);
      clear_i = 1'b0;
      chk("clr_locked", int'(locked_o), 0);
      chk("clr_error", int'(error_o), 0);
      chk("clr_errs", int'(err_count_o), 0);
      chk("clr_beats", int'(beat_count_o), 0);
      chk("clr_lines", int'(line_count_o), 0);
      chk("clr_fe", int'(first_exp_o), 0);
      chk("clr_fg", int'(first_got_o), 0);

      // Pre-lock beats are counted but not checked; then lock at 0x40.
      beat(8'd3, 1'b0, 1'b0);
      beat(8'd9, 1'b0, 1'b0);
      beat(8'd2, 1'b0, 1'b0);
      chk("prelock_locked", int'(locked_o), 0);
      chk("prelock_errs", int'(err_count_o), 0);
      chk("prelock_beats", int'(beat_count_o), 3);
      beat(8'h40, 1'b1, 1'b0);
      beat(8'h41, 1'b0, 1'b0);
      chk("relock_locked", int'(locked_o), 1);
      chk("relock_errs", int'(err_count_o), 0);
      chk("relock_frames", int'(frame_count_o), 1);

      // Wrap at 8 bits: 0xFE(tuser),0xFF,0x00,0x01.
      do_clear();
      beat(8'hFE, 1'b1, 1'b0);
      beat(8'hFF, 1'b0, 1'b0);
      beat(8'h00, 1'b0, 1'b0);
      beat(8'h01, 1'b0, 1'b0);
      chk("wrap_errs", int'(err_count_o), 0);
      chk("wrap_locked", int'(locked_o), 1);

      // Async reset mid-frame, between clock edges.
      beat(8'h20, 1'b1, 1'b0);
      beat(8'h21, 1'b0, 1'b0);
      s_axis_tdata = 8'h22; s_axis_tvalid = 1'b1;
      #2 rst_ni = 1'b0;
      #1 all_zero("async_rst");
      s_axis_tvalid = 1'b0;
      @(negedge clk_i);
      #1 rst_ni = 1'b1;
      chk("rst_rel_tready", int'(s_axis_tready), 0);
      @(negedge clk_i);
      beat(8'h23, 1'b0, 1'b0);
      chk("post_rst_locked", int'(locked_o), 0);
      chk("post_rst_beats", int'(beat_count_o), 1);
      chk("post_rst_errs", int'(err_count_o), 0);

      // Randomized traffic; clears only early so counters reach saturation.
      cnt = 0;
      for (int c = 0; c < 900; c++) begin
         d = 8'(cnt);
         if ($urandom_range(0, 24) == 0) d = 8'($urandom);
         s_axis_tdata  = d;
         s_axis_tvalid = ($urandom_range(0, 3) != 0);
         s_axis_tuser  = ($urandom_range(0, 39) == 0);
         s_axis_tlast  = ($urandom_range(0, 15) == 0);
         clear_i       = (c < 100) && ($urandom_range(0, 49) == 0);
         if (s_axis_tvalid && s_axis_tready) cnt = (int'(d) + 1) % 256;
         @(negedge clk_i);
      end
      s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0; clear_i = 1'b0;
      @(negedge clk_i);
      chk("sat_beats", int'(beat_count_o), CNT_MAX);
`ifdef COUNT_CHECK_STALL_EN
      chk("lfsr_toggles", int'(rdy_hi > 0 && rdy_lo > 0), 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
